// File: rtl/demux_1_8.sv
// rtl/demux_1_8.sv - 1-to-8 demultiplexer with optional registered outputs
//
// Purpose:
//   Routes data input I to one of eight output lanes chosen by the 3-bit select s.
//   Every unselected lane is 0. y_sel is a one-hot copy of the active lane.
//   With REG_OUT=1 the outputs are registered on clk, with one cycle of latency.
//   With REG_OUT=0 the outputs are purely combinational, and clk and rst are unused.
//
// Ports:
//   clk   in   1      system clock, rising-edge active
//   rst   in   1      asynchronous, active-high reset (clears outputs at once)
//   en    in   1      enable; 0 forces every lane and y_sel to 0
//   I     in   DW     data to route
//   s     in   3      lane select, 0..7
//   y     out  8*DW   lanes; lane k is y[k*DW +: DW]
//   y_sel out  8      one-hot active lane, independent of I

module demux_1_8 #(
  parameter int DW      = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DW-1:0]   I,
  input  logic [2:0]      s,
  output logic [8*DW-1:0] y,
  output logic [7:0]      y_sel
);

  logic [8*DW-1:0] y_d;
  logic [7:0]      y_sel_d;

  // Start from all-zero so unselected lanes can never carry X or stale data.
  always_comb begin
    y_d     = '0;
    y_sel_d = '0;
    if (en) begin
      y_sel_d[s]         = 1'b1;
      y_d[s*DW +: DW]    = I;
    end
  end

  if (REG_OUT) begin : g_reg
    logic [8*DW-1:0] y_q;
    logic [7:0]      y_sel_q;

    // The asynchronous clear also discards whatever value was about to be
    // loaded, so no stale lane can appear after reset is released.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        y_q     <= '0;
        y_sel_q <= '0;
      end else begin
        y_q     <= y_d;
        y_sel_q <= y_sel_d;
      end
    end

    assign y     = y_q;
    assign y_sel = y_sel_q;
  end else begin : g_comb
    // The combinational build has no state, so clk and rst are unused.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign y     = y_d;
    assign y_sel = y_sel_d;
  end

endmodule

// File: tb/tb_demux_1_8.sv
// tb/tb_demux_1_8.sv - directed self-checking bench for demux_1_8

module tb_demux_1_8;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  s;
  logic        i1;
  logic [3:0]  i4;
  logic        ic;
  logic [7:0]  y1;
  logic [7:0]  sel1;
  logic [31:0] y4;
  logic [7:0]  sel4;
  logic [7:0]  yc;
  logic [7:0]  selc;

  int checks;
  int failures;

  demux_1_8 #(.DW(1), .REG_OUT(1'b1)) u_reg1 (
    .clk(clk), .rst(rst), .en(en), .I(i1), .s(s), .y(y1), .y_sel(sel1)
  );

  demux_1_8 #(.DW(4), .REG_OUT(1'b1)) u_reg4 (
    .clk(clk), .rst(rst), .en(en), .I(i4), .s(s), .y(y4), .y_sel(sel4)
  );

  demux_1_8 #(.DW(1), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .en(en), .I(ic), .s(s), .y(yc), .y_sel(selc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; s = 3'd3; i1 = 1'b1; i4 = 4'h0; ic = 1'b0;
    tick();
    checks++;
    if (y1 !== 8'h00 || sel1 !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold: y=%h y_sel=%h expected y=00 y_sel=00", y1, sel1);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (y1 !== 8'h08) begin
      failures++;
      $display("FAIL reset_pre_y: y=%h expected 08", y1);
    end
    // Assert reset mid-cycle; outputs must clear without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (y1 !== 8'h00 || sel1 !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: y=%h y_sel=%h expected y=00 y_sel=00", y1, sel1);
    end
    s = 3'd5;
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (y1 !== 8'h00 || sel1 !== 8'h00) begin
      failures++;
      $display("FAIL reset_no_stale: y=%h y_sel=%h expected y=00 y_sel=00", y1, sel1);
    end
    tick();
    checks++;
    if (y1 !== 8'h20 || sel1 !== 8'h20) begin
      failures++;
      $display("FAIL reset_first_edge: y=%h y_sel=%h expected y=20 y_sel=20", y1, sel1);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_y [8];
    logic [7:0] exp_sel [8];
    exp_y   = '{8'h00, 8'h02, 8'h00, 8'h08, 8'h00, 8'h20, 8'h00, 8'h80};
    exp_sel = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s  = 3'(k);
      i1 = k[0];
      tick();
      checks++;
      if (y1 !== exp_y[k] || sel1 !== exp_sel[k]) begin
        failures++;
        $display("FAIL sweep_s%0d: y=%h y_sel=%h expected y=%h y_sel=%h",
                 k, y1, sel1, exp_y[k], exp_sel[k]);
      end
    end
  endtask

  task automatic test_enable();
    en = 1'b0; s = 3'd6; i1 = 1'b1;
    tick();
    checks++;
    if (y1 !== 8'h00 || sel1 !== 8'h00) begin
      failures++;
      $display("FAIL enable_off: y=%h y_sel=%h expected y=00 y_sel=00", y1, sel1);
    end
    en = 1'b1;
    tick();
    checks++;
    if (y1 !== 8'h40 || sel1 !== 8'h40) begin
      failures++;
      $display("FAIL enable_on: y=%h y_sel=%h expected y=40 y_sel=40", y1, sel1);
    end
    i1 = 1'b0; s = 3'd4;
    tick();
    checks++;
    if (y1 !== 8'h00 || sel1 !== 8'h10) begin
      failures++;
      $display("FAIL enable_zero_data: y=%h y_sel=%h expected y=00 y_sel=10", y1, sel1);
    end
  endtask

  task automatic test_latency();
    en = 1'b1; s = 3'd2; i1 = 1'b1;
    tick();
    checks++;
    if (y1 !== 8'h04) begin
      failures++;
      $display("FAIL latency_before: y=%h expected 04", y1);
    end
    #1;
    s = 3'd6;
    #2;
    checks++;
    if (y1 !== 8'h04 || sel1 !== 8'h04) begin
      failures++;
      $display("FAIL latency_hold: y=%h y_sel=%h expected y=04 y_sel=04", y1, sel1);
    end
    tick();
    checks++;
    if (y1 !== 8'h40 || sel1 !== 8'h40) begin
      failures++;
      $display("FAIL latency_after: y=%h y_sel=%h expected y=40 y_sel=40", y1, sel1);
    end
  endtask

  task automatic test_wide();
    en = 1'b1; s = 3'd7; i4 = 4'hA;
    tick();
    checks++;
    if (y4 !== 32'hA000_0000 || sel4 !== 8'h80) begin
      failures++;
      $display("FAIL wide_s7: y=%h y_sel=%h expected y=a0000000 y_sel=80", y4, sel4);
    end
    s = 3'd0; i4 = 4'h5;
    tick();
    checks++;
    if (y4 !== 32'h0000_0005 || sel4 !== 8'h01) begin
      failures++;
      $display("FAIL wide_s0: y=%h y_sel=%h expected y=00000005 y_sel=01", y4, sel4);
    end
    s = 3'd3; i4 = 4'hF;
    tick();
    checks++;
    if (y4 !== 32'h0000_F000 || sel4 !== 8'h08) begin
      failures++;
      $display("FAIL wide_s3: y=%h y_sel=%h expected y=0000f000 y_sel=08", y4, sel4);
    end
  endtask

  task automatic test_comb();
    // Drive mid-cycle so that no clock edge falls between stimulus and sample.
    @(negedge clk);
    en = 1'b1; s = 3'd3; ic = 1'b1;
    #1;
    checks++;
    if (yc !== 8'h08 || selc !== 8'h08) begin
      failures++;
      $display("FAIL comb_s3: y=%h y_sel=%h expected y=08 y_sel=08", yc, selc);
    end
    s = 3'd7; ic = 1'b0;
    #1;
    checks++;
    if (yc !== 8'h00 || selc !== 8'h80) begin
      failures++;
      $display("FAIL comb_zero_data: y=%h y_sel=%h expected y=00 y_sel=80", yc, selc);
    end
    en = 1'b0; ic = 1'b1;
    #1;
    checks++;
    if (yc !== 8'h00 || selc !== 8'h00) begin
      failures++;
      $display("FAIL comb_disabled: y=%h y_sel=%h expected y=00 y_sel=00", yc, selc);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sweep();
    test_enable();
    test_latency();
    test_wide();
    test_comb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1_8.md
Name: demux_1_8

Overview:
- 1-to-8 demultiplexer: routes data input I to one of eight output lanes chosen by the 3-bit select s.
- All unselected lanes are driven to 0.
- Used as a generic routing/steering primitive, e.g. decoded write-enable or data fan-out.
- Output is registered by default (one-cycle latency); a parameter selects a purely combinational build.

Parameters:
- DW, 1: data width of I and of each output lane.
- REG_OUT, 1: 1 = outputs registered on clk; 0 = outputs combinational from I, s, en.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enable. When 0, all lanes are driven to 0.
- I  input  DW  data input to be routed.
- s  input  3  lane select, binary 0..7.
- y  output  8*DW  output lanes. Lane k occupies bits [k*DW +: DW]; with DW=1, y[k] is lane k.
- y_sel  output  8  one-hot copy of the active lane, independent of I. All zero when en=0.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Decode function, for k = 0..7:
  - lane_k = I when (en=1 and s==k), else 0.
  - sel_k = 1 when (en=1 and s==k), else 0.
- REG_OUT=1:
  - On each rising clk edge with rst=0: y <= lanes, y_sel <= sels.
  - Latency: exactly 1 cycle from I/s/en to y/y_sel.
  - No internal state beyond the output registers.
- REG_OUT=0:
  - y and y_sel follow the inputs combinationally with zero latency.
  - rst and clk are unused.
- Reset (REG_OUT=1):
  - rst=1 forces y=0 and y_sel=0 immediately, without waiting for a clock edge.
  - Outputs hold 0 while rst is high.
  - The first update occurs on the first rising clk after rst deasserts.
  - Reset asserted mid-stream discards the pending value; no stale lane appears after release.
- Output invariants:
  - At most one lane can be nonzero at any time.
  - When I=0 and en=1, y=0 but y_sel is still one-hot.
  - No X propagation from unselected lanes; each lane is 0 unless selected.
- Select changes: a change on s between edges affects only the next registered value; no glitch on registered outputs.
- Select boundaries: s=0 drives lane 0 (LSB lane); s=7 drives lane 7 (MSB lane). There is no wrap and no invalid select code.
- Simultaneous en=0 and any s/I change: outputs become 0 at the next edge (REG_OUT=1) or immediately (REG_OUT=0).

Test Plan:
- Reset: assert rst asynchronously mid-cycle while y=8'b0000_1000 -> y=0 and y_sel=0 immediately; after release with s=3'b101, I=1, en=1, y=8'b0010_0000 on the first clk edge.
- Sweep (DW=1, en=1): s=0..7 with I alternating 0,1 starting at 0 -> one cycle later, y=0 for even s; for odd s, y=1<<s (s=1 -> 8'h02, s=3 -> 8'h08, s=5 -> 8'h20, s=7 -> 8'h80). y_sel=1<<s in every case.
- Enable: en=0, s=3'b110, I=1 -> y=0 and y_sel=0 after one edge. Raise en -> y=8'h40 and y_sel=8'h40 next edge.
- Latency: change s from 2 to 6 with I=1 and en=1 -> y stays 8'h04 until the next rising edge, then becomes 8'h40. No intermediate value is visible.
- Wide data (DW=4): I=4'hA, s=3'b111 -> y[31:28]=4'hA, all other bits 0.
- Combinational build (REG_OUT=0): s=3'b011, I=1 -> y=8'h08 within the same delta cycle, with no clock edge applied.
